// File: rtl/mtr_pwm_drv_if.sv
// Motor PWM driver bus: speed commands and enable in, bridge PWM legs and
// period-start strobe out.
//   en        drive enable (low forces coast)
//   lft_spd   signed left speed command
//   rght_spd  signed right speed command
//   lft_fwd / lft_rev / rght_fwd / rght_rev   bridge leg PWMs
//   prd_strt  one-cycle strobe marking the first output cycle of a period
interface mtr_pwm_drv_if #(
    parameter int SPD_W = 12
);
    logic             en;
    logic [SPD_W-1:0] lft_spd;
    logic [SPD_W-1:0] rght_spd;
    logic             lft_fwd;
    logic             lft_rev;
    logic             rght_fwd;
    logic             rght_rev;
    logic             prd_strt;

    modport master (
        output en, lft_spd, rght_spd,
        input  lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt
    );

    modport slave (
        input  en, lft_spd, rght_spd,
        output lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt
    );
endinterface

// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: converts signed left/right speed commands into PWM pairs for
// two H-bridges. Duty and direction change only at PWM period boundaries, and a
// direction reversal is forced through a coast interval of REV_HOLD periods.
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   mtr_pwm_drv_if.slave (en, lft_spd, rght_spd in;
//         lft_fwd, lft_rev, rght_fwd, rght_rev, prd_strt out)

// Per-motor channel: direction FSM, duty register and registered PWM legs.
module mtr_pwm_ch #(
    parameter int CNT_W    = 11,
    parameter int REV_HOLD = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bnd,
    input  logic             en,
    input  logic [CNT_W-1:0] cnt,
    input  logic [CNT_W:0]   spd,
    output logic             fwd,
    output logic             rev
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FWD  = 2'd1;
    localparam logic [1:0] ST_REV  = 2'd2;
    localparam logic [1:0] ST_HOLD = 2'd3;

    localparam logic [1:0] DIR_NONE = 2'd0;
    localparam logic [1:0] DIR_FWD  = 2'd1;
    localparam logic [1:0] DIR_REV  = 2'd2;

    localparam int               HW        = (REV_HOLD > 1) ? $clog2(REV_HOLD) : 1;
    localparam logic [HW-1:0]    HOLD_INIT = HW'(REV_HOLD - 1);
    localparam logic [CNT_W-1:0] MAG_MAX   = '1;

    logic [1:0]       st, st_nxt;
    logic [1:0]       dir, dir_nxt, ldir;
    logic [HW-1:0]    hold, hold_nxt;
    logic [CNT_W-1:0] duty, duty_nxt, mag;
    logic [CNT_W:0]   spd_neg;
    logic             is_pos, is_neg, from_idle;

    assign spd_neg = -spd;
    assign is_neg  = spd[CNT_W];
    assign is_pos  = !spd[CNT_W] && (|spd[CNT_W-1:0]);

    // |spd| saturated: the most negative command has no positive twin.
    always_comb begin
        mag = spd[CNT_W-1:0];
        if (is_neg)
            mag = (spd[CNT_W-1:0] == '0) ? MAG_MAX : spd_neg[CNT_W-1:0];
    end

    always_comb begin
        st_nxt    = st;
        dir_nxt   = dir;
        hold_nxt  = hold;
        duty_nxt  = duty;
        from_idle = 1'b0;
        ldir      = dir;
        if (bnd) begin
            if (!en) begin
                st_nxt   = ST_IDLE;
                duty_nxt = '0;
            end else begin
                case (st)
                    ST_IDLE: from_idle = 1'b1;
                    ST_FWD: begin
                        if (is_neg) begin
                            st_nxt   = ST_HOLD;
                            hold_nxt = HOLD_INIT;
                        end else if (!is_pos) begin
                            st_nxt = ST_IDLE;
                        end
                    end
                    ST_REV: begin
                        if (is_pos) begin
                            st_nxt   = ST_HOLD;
                            hold_nxt = HOLD_INIT;
                        end else if (!is_neg) begin
                            st_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        if (hold != '0) begin
                            hold_nxt = hold - 1'b1;
                        end else begin
                            // Coast served: forget the old direction so any
                            // sign may start straight away.
                            dir_nxt   = DIR_NONE;
                            ldir      = DIR_NONE;
                            from_idle = 1'b1;
                        end
                    end
                endcase
                if (from_idle) begin
                    if (is_pos) begin
                        if (ldir == DIR_REV) begin
                            st_nxt   = ST_HOLD;
                            hold_nxt = HOLD_INIT;
                        end else begin
                            st_nxt = ST_FWD;
                        end
                    end else if (is_neg) begin
                        if (ldir == DIR_FWD) begin
                            st_nxt   = ST_HOLD;
                            hold_nxt = HOLD_INIT;
                        end else begin
                            st_nxt = ST_REV;
                        end
                    end else begin
                        st_nxt = ST_IDLE;
                    end
                end
                if (st_nxt == ST_FWD) dir_nxt = DIR_FWD;
                if (st_nxt == ST_REV) dir_nxt = DIR_REV;
                duty_nxt = (st_nxt == ST_FWD || st_nxt == ST_REV) ? mag : '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st   <= ST_IDLE;
            dir  <= DIR_NONE;
            hold <= '0;
            duty <= '0;
            fwd  <= 1'b0;
            rev  <= 1'b0;
        end else begin
            st   <= st_nxt;
            dir  <= dir_nxt;
            hold <= hold_nxt;
            duty <= duty_nxt;
            fwd  <= en && (st == ST_FWD) && (cnt < duty);
            rev  <= en && (st == ST_REV) && (cnt < duty);
        end
    end
endmodule

module mtr_pwm_drv #(
    parameter int CNT_W    = 11,
    parameter int REV_HOLD = 2
) (
    input  logic           clk,
    input  logic           rst,
    mtr_pwm_drv_if.slave   bus
);
    localparam int NUM_MTR = 2;

    logic [CNT_W-1:0]              cnt;
    logic                          bnd;
    logic                          armed;
    logic [NUM_MTR-1:0][CNT_W:0]   spd;
    logic [NUM_MTR-1:0]            fwd, rev;

    assign bnd    = &cnt;
    assign spd[0] = bus.lft_spd;
    assign spd[1] = bus.rght_spd;

    // The cnt==0 cycle straight out of reset is not announced: prd_strt marks
    // only periods entered through a boundary, where duties were latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            armed        <= 1'b0;
            bus.prd_strt <= 1'b0;
        end else begin
            cnt          <= cnt + 1'b1;
            if (bnd) armed <= 1'b1;
            bus.prd_strt <= armed && (cnt == '0);
        end
    end

    for (genvar g = 0; g < NUM_MTR; g++) begin : g_ch
        mtr_pwm_ch #(.CNT_W(CNT_W), .REV_HOLD(REV_HOLD)) u_ch (
            .clk (clk),
            .rst (rst),
            .bnd (bnd),
            .en  (bus.en),
            .cnt (cnt),
            .spd (spd[g]),
            .fwd (fwd[g]),
            .rev (rev[g])
        );
    end

    assign bus.lft_fwd  = fwd[0];
    assign bus.lft_rev  = rev[0];
    assign bus.rght_fwd = fwd[1];
    assign bus.rght_rev = rev[1];
endmodule

// File: tb/tb_mtr_pwm_drv.sv
// Bench for mtr_pwm_drv: per-period high-cycle counts of every leg are
// compared with a period-level reference model; directed sequence, mid-period
// reset, then randomized commands.
module tb_mtr_pwm_drv;
    localparam int PRD      = 2048;
    localparam int REV_HOLD = 2;
    localparam int N_DIR    = 17;
    localparam int N_RND    = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mtr_pwm_drv_if bus ();

    mtr_pwm_drv #(.CNT_W(11), .REV_HOLD(REV_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model, one step per period: drive sign, duty, coast periods
    // still owed, and last driven sign.
    int drv[2], duty[2], hold[2], last[2];
    bit cur_en;
    int pnum = 0;

    int d_en[N_DIR] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1};
    int d_l[N_DIR]  = '{'h200, 'h200, 'h400, -'h400, -'h400, -'h400, 0, 'h300, 'h300,
                        'h300, 0, -'h300, -'h300, -'h300, -'h300, -'h300, -'h300};
    int d_r[N_DIR]  = '{-'h100, -'h800, 'h7FF, 'h7FF, 0, 0, 'h100, 'h100, 'h100,
                        -'h100, -'h100, -'h100, -'h100, -'h100, -'h100, -'h100, -'h100};

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sgn(input int v);
        return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
    endfunction

    function automatic int magf(input int v);
        int m;
        m = (v < 0) ? -v : v;
        return (m > 2047) ? 2047 : m;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic mdl_reset();
        for (int m = 0; m < 2; m++) begin
            drv[m] = 0; duty[m] = 0; hold[m] = 0; last[m] = 0;
        end
        cur_en = 1'b0;
    endtask

    // Start from rest: a sign opposite to the last driven one owes a coast.
    task automatic mdl_start(input int m, input int v);
        int s;
        s = sgn(v);
        if (s == 0) begin
            drv[m] = 0;
        end else if (s == -last[m]) begin
            drv[m] = 0; hold[m] = REV_HOLD;
        end else begin
            drv[m] = s; last[m] = s; duty[m] = magf(v);
        end
    endtask

    task automatic mdl_bnd(input int m, input bit e, input int v);
        int s;
        s = sgn(v);
        if (!e) begin
            drv[m] = 0; hold[m] = 0;
        end else if (hold[m] > 1) begin
            hold[m]--;
        end else if (hold[m] == 1) begin
            hold[m] = 0; last[m] = 0;
            mdl_start(m, v);
        end else if (drv[m] != 0 && s == drv[m]) begin
            duty[m] = magf(v);
        end else if (drv[m] != 0) begin
            if (s != 0) hold[m] = REV_HOLD;
            drv[m] = 0;
        end else begin
            mdl_start(m, v);
        end
    endtask

    // Called at the negedge showing the period's first output cycle; counts
    // the whole period, applies the next command mid-period, checks, and
    // returns at the first cycle of the following period.
    task automatic run_period(input bit e, input int l, input int r);
        int cf[2], cr[2];
        int nprd, prd0, both, cut, chg, ef, er;
        cf = '{0, 0}; cr = '{0, 0};
        nprd = 0; prd0 = 0; both = 0; cut = PRD;
        chg = int'($urandom_range(100, 1900));
        for (int i = 0; i < PRD; i++) begin
            if (i > 0) @(negedge clk);
            cf[0] += int'(bus.lft_fwd);
            cr[0] += int'(bus.lft_rev);
            cf[1] += int'(bus.rght_fwd);
            cr[1] += int'(bus.rght_rev);
            if (bus.prd_strt) begin
                nprd++;
                if (i == 0) prd0 = 1;
            end
            if ((bus.lft_fwd && bus.lft_rev) || (bus.rght_fwd && bus.rght_rev)) both++;
            if (i == chg) begin
                if (cur_en && !e) cut = chg + 1;
                bus.en       = e;
                bus.lft_spd  = 12'(l);
                bus.rght_spd = 12'(r);
            end
        end
        for (int m = 0; m < 2; m++) begin
            ef = (drv[m] > 0) ? imin(duty[m], cut) : 0;
            er = (drv[m] < 0) ? imin(duty[m], cut) : 0;
            chk($sformatf("p%0d %s_fwd", pnum, m ? "rght" : "lft"), cf[m], ef);
            chk($sformatf("p%0d %s_rev", pnum, m ? "rght" : "lft"), cr[m], er);
        end
        chk($sformatf("p%0d prd_strt_cnt", pnum), nprd, 1);
        chk($sformatf("p%0d prd_strt_first", pnum), prd0, 1);
        chk($sformatf("p%0d legs_overlap", pnum), both, 0);
        cur_en = e;
        mdl_bnd(0, e, l);
        mdl_bnd(1, e, r);
        pnum++;
        @(negedge clk);
    endtask

    // Release reset and wait (bounded) for the first period strobe.
    task automatic release_and_sync();
        int n;
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.prd_strt && n < 3000);
        chk("rst_to_prd_strt", n, 2049);
        mdl_reset();
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, " lft_fwd"},  int'(bus.lft_fwd),  0);
        chk({tag, " lft_rev"},  int'(bus.lft_rev),  0);
        chk({tag, " rght_fwd"}, int'(bus.rght_fwd), 0);
        chk({tag, " rght_rev"}, int'(bus.rght_rev), 0);
        chk({tag, " prd_strt"}, int'(bus.prd_strt), 0);
    endtask

    function automatic int rnd_spd();
        case ($urandom % 6)
            0:       return 0;
            1, 2:    return int'($urandom_range(1, 2047));
            3, 4:    return -int'($urandom_range(1, 2048));
            default: return 2047;
        endcase
    endfunction

    initial begin
        int exp_rev;
        bus.en       = 1'b0;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;
        repeat (3) @(negedge clk);
        chk_outs_zero("reset");
        release_and_sync();

        for (int k = 0; k < N_DIR; k++)
            run_period(d_en[k] != 0, d_l[k], d_r[k]);

        // Reset mid-period while the left reverse leg is active.
        repeat (10) @(negedge clk);
        exp_rev = (drv[0] < 0 && 10 < duty[0]) ? 1 : 0;
        chk("pre_rst lft_rev", int'(bus.lft_rev), exp_rev);
        #2 rst = 1'b1;
        #1 chk_outs_zero("mid_rst");
        bus.en       = 1'b0;
        bus.lft_spd  = '0;
        bus.rght_spd = '0;
        repeat (2) @(negedge clk);
        release_and_sync();

        for (int k = 0; k < N_RND; k++)
            run_period(($urandom % 8) != 0, rnd_spd(), rnd_spd());

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
